// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: operation encoding,
// controller state encoding and the datapath width of the ALU.
package alu_issue_ctrl_pkg;

    // Datapath width of the combinational ALU this controller drives.
    localparam int kALU_WIDTH = 16;

    // Operation encoding understood by the ALU.
    typedef enum logic [1:0] {
        kADD         = 2'b00,
        kSUB         = 2'b01,
        kPASS_INPUTA = 2'b10,
        kPASS_INPUTB = 2'b11
    } op_t;

    // Issue controller states: waiting for work, holding operands while the
    // ALU settles, and presenting a captured result to the consumer.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU operand interface. Registers an accepted request
// onto the ALU inputs, waits a programmable number of cycles for the
// combinational ALU to settle, captures its result into a response register
// and an accumulator, and hands the result out on a valid/ready port.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH         = kALU_WIDTH,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_acc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] acc_out,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_inputa,
    output logic [WIDTH-1:0] alu_inputb,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow
);

    // The settle counter counts down from SETTLE_CYCLES-1 to zero; capture
    // happens on the edge where it already reads zero.
    localparam logic [3:0] kSettleLoad = 4'(SETTLE_CYCLES - 1);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [3:0]  settle_cnt;
    logic        accept;
    logic        capture;

    assign accept  = (state == IDLE) && req_valid;
    assign capture = (state == ISSUE) && (settle_cnt == 4'd0);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> RESP -> IDLE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid)          state_next = ISSUE;
            ISSUE:   if (settle_cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready)          state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the registered state, so
    // req_ready never depends combinationally on req_valid.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Settle counter: loaded at acceptance, counts down while operands settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= kSettleLoad;
        end else if ((state == ISSUE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Operand registers feeding the ALU; only an accepted request changes
    // them, so they stay put through ISSUE and RESP. The accumulator source
    // is resolved here, using the result of the last completed operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op     <= kPASS_INPUTB;
            alu_inputa <= '0;
            alu_inputb <= '0;
        end else if (accept) begin
            alu_op     <= req_op;
            alu_inputa <= req_acc ? acc_out : req_a;
            alu_inputb <= req_b;
        end
    end

    // Result capture at the end of the settle window; the response register
    // and the accumulator both take the ALU output on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            acc_out      <= '0;
        end else if (capture) begin
            rsp_result   <= alu_out;
            rsp_overflow <= alu_overflow;
            acc_out      <= alu_out;
        end
    end

    // Sticky overflow: a captured overflow sets it and beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (capture && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: two controllers (settle times 1 and 3), each
// wired to its own behavioural ALU, driven through one set of request signals.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int W = kALU_WIDTH;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         req_valid1, req_valid3;
    logic [1:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic         req_acc;
    logic         rsp_ready;
    logic         clr_sticky;

    logic         req_ready1, rsp_valid1, rsp_ovf1, sticky1, alu_ovf1;
    logic [W-1:0] rsp_res1, acc1, alu_a1, alu_b1, alu_out1;
    logic [1:0]   alu_op1;
    logic         req_ready3, rsp_valid3, rsp_ovf3, sticky3, alu_ovf3;
    logic [W-1:0] rsp_res3, acc3, alu_a3, alu_b3, alu_out3;
    logic [1:0]   alu_op3;

    logic         sel;
    logic         obs_req_ready, obs_rsp_valid, obs_rsp_ovf, obs_sticky;
    logic [W-1:0] obs_rsp_res, obs_acc;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_result(rsp_res1),
        .rsp_overflow(rsp_ovf1), .acc_out(acc1), .sticky_ovf(sticky1),
        .clr_sticky(clr_sticky), .alu_op(alu_op1), .alu_inputa(alu_a1),
        .alu_inputb(alu_b1), .alu_out(alu_out1), .alu_overflow(alu_ovf1)
    );

    alu_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_result(rsp_res3),
        .rsp_overflow(rsp_ovf3), .acc_out(acc3), .sticky_ovf(sticky3),
        .clr_sticky(clr_sticky), .alu_op(alu_op3), .alu_inputa(alu_a3),
        .alu_inputb(alu_b3), .alu_out(alu_out3), .alu_overflow(alu_ovf3)
    );

    // Behavioural combinational ALU: {overflow, out}, signed overflow on add/sub.
    function automatic logic [W:0] alu_f(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        logic         o;
        r = '0;
        o = 1'b0;
        case (op)
            2'b00: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            2'b01: begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            2'b10: r = a;
            default: r = b;
        endcase
        return {o, r};
    endfunction

    // One ALU per controller.
    always_comb begin
        {alu_ovf1, alu_out1} = alu_f(alu_op1, alu_a1, alu_b1);
        {alu_ovf3, alu_out3} = alu_f(alu_op3, alu_a3, alu_b3);
    end

    // Observation mux so tasks can target either controller.
    always_comb begin
        obs_req_ready = sel ? req_ready3 : req_ready1;
        obs_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
        obs_rsp_res   = sel ? rsp_res3   : rsp_res1;
        obs_rsp_ovf   = sel ? rsp_ovf3   : rsp_ovf1;
        obs_acc       = sel ? acc3       : acc1;
        obs_sticky    = sel ? sticky3    : sticky1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive_valid(input logic v);
        if (sel) req_valid3 = v; else req_valid1 = v;
    endtask

    // Full transaction with rsp_ready high: waits for ready, issues, checks
    // latency, busy ready, result, overflow, accumulator and return to idle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc, input logic [W-1:0] exp_res, input logic exp_ovf);
        int   lat;
        int   wait_cnt;
        int   busy_bad;
        exp_t e;
        wait_cnt = 0;
        while (!obs_req_ready && wait_cnt < 20) begin
            @(posedge clk); #1; wait_cnt++;
        end
        checks++;
        if (obs_req_ready !== 1'b1) $display("[TB] FAIL req_ready_wait: got %b want 1", obs_req_ready);
        else passes++;
        req_op = op; req_a = a; req_b = b; req_acc = acc;
        drive_valid(1'b1);
        sb.push_back('{res: exp_res, ovf: exp_ovf});
        @(posedge clk); #1;
        drive_valid(1'b0);
        lat = 0;
        busy_bad = 0;
        while (!obs_rsp_valid && lat < 20) begin
            if (obs_req_ready !== 1'b0) busy_bad++;
            @(posedge clk); #1; lat++;
        end
        if (obs_req_ready !== 1'b0) busy_bad++;
        checks++;
        if (lat !== (sel ? 3 : 1)) $display("[TB] FAIL latency: got %0d want %0d", lat, sel ? 3 : 1);
        else passes++;
        checks++;
        if (busy_bad !== 0) $display("[TB] FAIL req_ready_busy: got %0d high cycles want 0", busy_bad);
        else passes++;
        checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if (obs_rsp_res !== e.res || obs_rsp_ovf !== e.ovf)
                $display("[TB] FAIL rsp: got %h/%b want %h/%b", obs_rsp_res, obs_rsp_ovf, e.res, e.ovf);
            else passes++;
        end
        checks++;
        if (obs_acc !== exp_res) $display("[TB] FAIL acc_out: got %h want %h", obs_acc, exp_res);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (obs_rsp_valid !== 1'b0 || obs_req_ready !== 1'b1)
            $display("[TB] FAIL return_idle: got valid=%b ready=%b want 0/1", obs_rsp_valid, obs_req_ready);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_res1 !== '0 || rsp_ovf1 !== 1'b0 || acc1 !== '0 || sticky1 !== 1'b0)
            $display("[TB] FAIL reset_rsp: got %b %h %b %h %b want 0 0000 0 0000 0",
                     rsp_valid1, rsp_res1, rsp_ovf1, acc1, sticky1);
        else passes++;
        checks++;
        if (alu_op1 !== 2'b11 || alu_a1 !== '0 || alu_b1 !== '0)
            $display("[TB] FAIL reset_alu: got %b %h %h want 11 0000 0000", alu_op1, alu_a1, alu_b1);
        else passes++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready1 !== 1'b1 || req_ready3 !== 1'b1 || rsp_valid3 !== 1'b0)
            $display("[TB] FAIL reset_ready: got %b %b %b want 1 1 0", req_ready1, req_ready3, rsp_valid3);
        else passes++;
    endtask

    task automatic test_add();
        sel = 1'b0;
        run_op(2'b00, 16'h0044, 16'h0044, 1'b0, 16'h0088, 1'b0);
    endtask

    task automatic test_sub_pass();
        sel = 1'b0;
        run_op(2'b01, 16'h0044, 16'h0044, 1'b0, 16'h0000, 1'b0);
        run_op(2'b11, 16'h1234, 16'h0022, 1'b0, 16'h0022, 1'b0);
    endtask

    task automatic test_sticky();
        exp_t e;
        sel = 1'b0;
        run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
        checks++;
        if (sticky1 !== 1'b1) $display("[TB] FAIL sticky_set: got %b want 1", sticky1);
        else passes++;
        run_op(2'b11, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0);
        checks++;
        if (sticky1 !== 1'b1) $display("[TB] FAIL sticky_hold: got %b want 1", sticky1);
        else passes++;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (sticky1 !== 1'b0) $display("[TB] FAIL sticky_clear: got %b want 0", sticky1);
        else passes++;
        // Overflow capture coinciding with a clear: set must win.
        req_op = 2'b00; req_a = 16'h7FFF; req_b = 16'h0001; req_acc = 1'b0;
        req_valid1 = 1'b1;
        sb.push_back('{res: 16'h8000, ovf: 1'b1});
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        checks++;
        if (sticky1 !== 1'b1 || rsp_valid1 !== 1'b1)
            $display("[TB] FAIL sticky_set_wins: got sticky=%b valid=%b want 1/1", sticky1, rsp_valid1);
        else passes++;
        checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if (rsp_res1 !== e.res || rsp_ovf1 !== e.ovf)
                $display("[TB] FAIL sticky_rsp: got %h/%b want %h/%b", rsp_res1, rsp_ovf1, e.res, e.ovf);
            else passes++;
        end
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
    endtask

    task automatic test_accumulate();
        sel = 1'b0;
        run_op(2'b11, 16'h0000, 16'h0022, 1'b0, 16'h0022, 1'b0);
        run_op(2'b00, 16'hFFFF, 16'h0010, 1'b1, 16'h0032, 1'b0);
    endtask

    task automatic test_back_to_back_settle3();
        sel = 1'b1;
        run_op(2'b01, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
        run_op(2'b00, 16'h0000, 16'h0003, 1'b1, 16'h0001, 1'b0);
    endtask

    task automatic test_backpressure();
        int   lat;
        int   bad;
        exp_t e;
        sel = 1'b1;
        rsp_ready = 1'b0;
        req_op = 2'b00; req_a = 16'h0100; req_b = 16'h0023; req_acc = 1'b0;
        req_valid3 = 1'b1;
        sb.push_back('{res: 16'h0123, ovf: 1'b0});
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        lat = 0;
        while (!rsp_valid3 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 3) $display("[TB] FAIL bp_latency: got %0d want 3", lat);
        else passes++;
        // Offer a competing request while the response is stalled.
        req_op = 2'b11; req_b = 16'hBEEF;
        req_valid3 = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid3 !== 1'b1 || rsp_res3 !== 16'h0123 || req_ready3 !== 1'b0) bad++;
        end
        req_valid3 = 1'b0;
        checks++;
        if (bad !== 0) $display("[TB] FAIL bp_hold: got %0d bad cycles want 0", bad);
        else passes++;
        checks++;
        if (alu_b3 !== 16'h0023 || alu_op3 !== 2'b00)
            $display("[TB] FAIL bp_no_accept: got op=%b b=%h want 00/0023", alu_op3, alu_b3);
        else passes++;
        checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            if (rsp_res3 !== e.res || rsp_ovf3 !== e.ovf)
                $display("[TB] FAIL bp_rsp: got %h/%b want %h/%b", rsp_res3, rsp_ovf3, e.res, e.ovf);
            else passes++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1)
            $display("[TB] FAIL bp_release: got valid=%b ready=%b want 0/1", rsp_valid3, req_ready3);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid3 !== 1'b0 || alu_b3 !== 16'h0023)
            $display("[TB] FAIL bp_no_stale: got valid=%b b=%h want 0/0023", rsp_valid3, alu_b3);
        else passes++;
    endtask

    task automatic test_reset_mid_issue();
        int bad;
        sel = 1'b1;
        req_op = 2'b00; req_a = 16'h0001; req_b = 16'h0001; req_acc = 1'b0;
        req_valid3 = 1'b1;
        sb.push_back('{res: 16'h0002, ovf: 1'b0});
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid3 !== 1'b0 || rsp_res3 !== '0 || acc3 !== '0 || sticky3 !== 1'b0 || acc1 !== '0)
            $display("[TB] FAIL mid_reset_outputs: got %b %h %h %b %h want 0 0000 0000 0 0000",
                     rsp_valid3, rsp_res3, acc3, sticky3, acc1);
        else passes++;
        checks++;
        if (alu_op3 !== 2'b11 || alu_a3 !== '0 || alu_b3 !== '0)
            $display("[TB] FAIL mid_reset_alu: got %b %h %h want 11 0000 0000", alu_op3, alu_a3, alu_b3);
        else passes++;
        sb.delete();
        #3;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) $display("[TB] FAIL mid_reset_discard: got %0d bad cycles want 0", bad);
        else passes++;
    endtask

    initial begin
        sel        = 1'b0;
        rst_n      = 1'b1;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_acc    = 1'b0;
        rsp_ready  = 1'b1;
        clr_sticky = 1'b0;
        #3;
        test_reset();
        test_add();
        test_sub_pass();
        test_sticky();
        test_accumulate();
        test_back_to_back_settle3();
        test_backpressure();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
